b06_datapath: RTL

- Datapath/counter stage that sits directly downstream of the b06 control FSM and closes its loop.
- Consumes the FSM's cc_mux, enable_count, ackout and uscite. Produces the eql and cont_eql status bits the FSM samples.
- Holds a reference operand, compares incoming data against it, runs the dwell counter, and turns ackout into an acknowledge pulse plus a saturating count.

---
 rtl/b06_pkg.sv | 22 ++
 rtl/b06_dwell_counter.sv | 43 ++++
 rtl/b06_datapath.sv | 128 ++++++++++++
 3 files changed

// File: rtl/b06_pkg.sv
// ----------------------------------------------------------------------------
// b06_pkg
// Shared constants for the b06 control/datapath pair.
//   - cc_mux mode codes driven by the control FSM
//   - uscite output code values
//   - acknowledge counter width
// ----------------------------------------------------------------------------
package b06_pkg;

    localparam logic [1:0] CC_IDLE  = 2'b00;
    localparam logic [1:0] CC_LOAD  = 2'b01;
    localparam logic [1:0] CC_EXACT = 2'b10;
    localparam logic [1:0] CC_MASK  = 2'b11;

    localparam logic [1:0] USC_NONE = 2'b00;
    localparam logic [1:0] USC_1    = 2'b01;
    localparam logic [1:0] USC_2    = 2'b10;
    localparam logic [1:0] USC_3    = 2'b11;

    localparam int ACK_CNT_W = 8;

endpackage

// File: rtl/b06_dwell_counter.sv
// ----------------------------------------------------------------------------
// b06_dwell_counter
// Terminal-count dwell timer. Counts up while enabled, stops at CNT_MAX
// without wrapping, and clears as soon as enable drops.
// Ports:
//   clock    : rising-edge clock
//   reset    : synchronous, active-high reset
//   enable   : count enable
//   cont_eql : registered, high while the count sits at CNT_MAX
// ----------------------------------------------------------------------------
module b06_dwell_counter #(
    parameter int CNT_MAX = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic cont_eql
);

    localparam logic [7:0] TERM = 8'(CNT_MAX);

    logic [7:0] count;
    logic [7:0] count_nxt;

    always_comb begin
        count_nxt = 8'd0;
        if (enable) begin
            count_nxt = (count < TERM) ? count + 8'd1 : count;
        end
    end

    // cont_eql is derived from the next count so it lines up with count itself.
    always_ff @(posedge clock) begin
        if (reset) begin
            count    <= 8'd0;
            cont_eql <= 1'b0;
        end else begin
            count    <= count_nxt;
            cont_eql <= (count_nxt == TERM);
        end
    end

endmodule

// File: rtl/b06_datapath.sv
// ----------------------------------------------------------------------------
// b06_datapath
// Datapath stage downstream of the b06 control FSM: reference register,
// exact/masked compare, dwell counter and acknowledge edge detector.
// Every output is registered with one cycle of latency.
// Ports:
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   cc_mux         : 00 idle, 01 load, 10 exact compare, 11 masked compare
//   enable_count   : dwell counter enable
//   ackout         : acknowledge level from the FSM
//   uscite         : FSM output code, re-registered on out_code
//   data_in/_valid : operand and its qualifier
//   eql            : compare result
//   cont_eql       : dwell counter at terminal count
//   ref_q          : reference register
//   out_code       : registered uscite
//   ack_pulse      : one-cycle pulse on ackout rising edge
//   ack_cnt        : saturating count of acknowledge pulses
// Build option B06_DATAPATH_PARITY_EN adds data_par (even parity over
// data_in) and par_err; a valid beat with bad parity flags par_err for one
// cycle, forces eql low and is not loaded.
// ----------------------------------------------------------------------------
module b06_datapath
    import b06_pkg::*;
#(
    parameter int             W       = 8,
    parameter int             CNT_MAX = 3,
    parameter logic [W-1:0]   MASK    = W'(8'hF0)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [1:0]           cc_mux,
    input  logic                 enable_count,
    input  logic                 ackout,
    input  logic [1:0]           uscite,
    input  logic [W-1:0]         data_in,
    input  logic                 data_in_valid,
    output logic                 eql,
    output logic                 cont_eql,
    output logic [W-1:0]         ref_q,
    output logic [1:0]           out_code,
    output logic                 ack_pulse,
    output logic [ACK_CNT_W-1:0] ack_cnt
`ifdef B06_DATAPATH_PARITY_EN
    ,
    input  logic                 data_par,
    output logic                 par_err
`endif
);

    logic par_bad;
    logic accept;
    logic ackout_q;
    logic ack_rise;

`ifdef B06_DATAPATH_PARITY_EN
    assign par_bad = data_in_valid & (^{data_in, data_par});
`else
    assign par_bad = 1'b0;
`endif

    assign accept   = data_in_valid & ~par_bad;
    assign ack_rise = ackout & ~ackout_q;

    b06_dwell_counter #(
        .CNT_MAX (CNT_MAX)
    ) u_dwell (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable_count),
        .cont_eql (cont_eql)
    );

    // Compare uses the current ref_q; loads only happen in CC_LOAD so the
    // two never collide.
    always_ff @(posedge clock) begin
        if (reset) begin
            eql   <= 1'b0;
            ref_q <= '0;
        end else begin
            case (cc_mux)
                CC_IDLE: eql <= 1'b0;
                CC_LOAD: begin
                    if (accept) begin
                        ref_q <= data_in;
                        eql   <= 1'b0;
                    end else if (par_bad) begin
                        eql <= 1'b0;
                    end
                end
                CC_EXACT: begin
                    if (accept)       eql <= (data_in == ref_q);
                    else if (par_bad) eql <= 1'b0;
                end
                default: begin
                    if (accept)       eql <= ((data_in & MASK) == (ref_q & MASK));
                    else if (par_bad) eql <= 1'b0;
                end
            endcase
        end
    end

    // The count advances on the same edge that raises ack_pulse, so both
    // outputs reflect a rising edge with the same latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            ackout_q  <= 1'b0;
            ack_pulse <= 1'b0;
            ack_cnt   <= '0;
            out_code  <= 2'b00;
        end else begin
            ackout_q  <= ackout;
            ack_pulse <= ack_rise;
            if (ack_rise && (ack_cnt != {ACK_CNT_W{1'b1}})) begin
                ack_cnt <= ack_cnt + 1'b1;
            end
            out_code  <= uscite;
        end
    end

`ifdef B06_DATAPATH_PARITY_EN
    always_ff @(posedge clock) begin
        if (reset) par_err <= 1'b0;
        else       par_err <= par_bad;
    end
`endif

endmodule
